// File: rtl/bcd_down_timer.sv
// Cascaded BCD down-counter with start/stop control.
// Digits chain by borrow; DONE pulses as the count reaches zero.
module bcd_down_timer #(
  parameter int DIGITS = 2
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   D,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  CE,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  RUN,
  output logic                  DONE,
  output logic                  ZERO
);

  typedef enum logic {
    IDLE,
    RUNNING
  } state_t;

  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] q_q, q_d;
  logic                done_q, done_d;
  logic [4*DIGITS-1:0] dec;
  logic [4*DIGITS-1:0] sat;

  // Per-digit saturation of the load value to 9.
  always_comb begin
    sat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (D[4*i +: 4] > 4'd9)
        sat[4*i +: 4] = 4'd9;
      else
        sat[4*i +: 4] = D[4*i +: 4];
    end
  end

  // Ripple-borrow BCD decrement; digit 0 always borrows.
  always_comb begin
    logic b;
    logic [3:0] dig;
    dec = q_q;
    b   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dig = q_q[4*i +: 4];
      if (b) begin
        if (dig == 4'd0) begin
          dec[4*i +: 4] = 4'd9;
          b = 1'b1;
        end else begin
          dec[4*i +: 4] = dig - 4'd1;
          b = 1'b0;
        end
      end
    end
  end

  // Next state: LOAD > STOP > START > CE decrement.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    done_d  = 1'b0;
    if (LOAD) begin
      q_d     = sat;
      state_d = IDLE;
    end else if (STOP) begin
      state_d = IDLE;
    end else if (START && state_q == IDLE) begin
      if (q_q != '0)
        state_d = RUNNING;
      else
        done_d = 1'b1;
    end else if (state_q == RUNNING && CE) begin
      q_d = dec;
      if (dec == '0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
    end
  end

  // State, count and pulse registers.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      q_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      done_q  <= done_d;
    end
  end

  assign Q    = q_q;
  assign RUN  = (state_q == RUNNING);
  assign DONE = done_q;
  assign ZERO = (q_q == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer, DIGITS=2.
// Inputs change 1ns after each rising edge; outputs checked there.
module tb_bcd_down_timer;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic       LOAD = 1'b0;
  logic [7:0] D = '0;
  logic       START = 1'b0;
  logic       STOP = 1'b0;
  logic       CE = 1'b0;
  logic [7:0] Q;
  logic       RUN, DONE, ZERO;

  int checks = 0;
  int errors = 0;

  bcd_down_timer #(.DIGITS(2)) dut (
    .CLK(CLK), .CLR(CLR), .LOAD(LOAD), .D(D),
    .START(START), .STOP(STOP), .CE(CE),
    .Q(Q), .RUN(RUN), .DONE(DONE), .ZERO(ZERO)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic ld, input logic [7:0] dv,
                     input logic st, input logic sp,
                     input logic ce);
    LOAD = ld; D = dv; START = st; STOP = sp; CE = ce;
    @(posedge CLK);
    #1;
    LOAD = 0; D = '0; START = 0; STOP = 0; CE = 0;
  endtask

  task automatic chk(input string tag, input logic [7:0] q,
                     input logic r, input logic d);
    check({tag, ".q"}, Q, q);
    check({tag, ".run"}, RUN, r);
    check({tag, ".done"}, DONE, d);
    check({tag, ".zero"}, ZERO, q == 8'h00);
  endtask

  logic [7:0] seq [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                           8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  logic [7:0] seq2 [5] = '{8'h19, 8'h18, 8'h17, 8'h16, 8'h15};

  initial begin
    #12;
    chk("reset", 8'h00, 0, 0);
    CLR = 0;
    @(posedge CLK); #1;

    cyc(1, 8'h37, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("pre_clr", 8'h37, 1, 0);
    CLR = 1;
    #2;
    chk("async_clr", 8'h00, 0, 0);
    CLR = 0;
    cyc(0, 8'h00, 0, 0, 1);
    chk("after_clr", 8'h00, 0, 0);

    cyc(1, 8'h12, 0, 0, 0);
    chk("load12", 8'h12, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("start12", 8'h12, 1, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 8'h00, 0, 0, 1);
      chk($sformatf("cnt%0d", i), seq[i], i != 11, i == 11);
    end
    cyc(0, 8'h00, 0, 0, 1);
    chk("hold00", 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0, 1);
    chk("restart00", 8'h00, 0, 1);

    cyc(1, 8'h3F, 0, 0, 0);
    chk("sat3f", 8'h39, 0, 0);
    cyc(1, 8'hA5, 0, 0, 0);
    chk("sata5", 8'h95, 0, 0);

    cyc(1, 8'h20, 0, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'h00, 0, 0, 1);
      chk($sformatf("slow%0d", i), seq2[i], 1, 0);
      cyc(0, 8'h00, 0, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      check($sformatf("slowhold%0d", i), Q, seq2[i]);
    end
    cyc(0, 8'h00, 0, 1, 1);
    chk("stop", 8'h15, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 8'h00, 0, 0, 1);
      chk($sformatf("stopped%0d", i), 8'h15, 0, 0);
    end
    cyc(0, 8'h00, 1, 0, 0);
    chk("resume", 8'h15, 1, 0);
    cyc(0, 8'h00, 1, 0, 1);
    chk("resume_ce", 8'h14, 1, 0);

    cyc(1, 8'h05, 1, 0, 1);
    chk("load_start", 8'h05, 0, 0);
    cyc(0, 8'h00, 1, 1, 0);
    chk("start_stop", 8'h05, 0, 0);
    cyc(0, 8'h00, 1, 0, 1);
    chk("start_ce", 8'h05, 1, 0);
    cyc(0, 8'h00, 0, 0, 1);
    chk("start_ce_next", 8'h04, 1, 0);
    cyc(1, 8'h07, 0, 0, 1);
    chk("load_run", 8'h07, 0, 0);

    cyc(1, 8'h00, 0, 0, 0);
    chk("load00", 8'h00, 0, 0);
    cyc(0, 8'h00, 1, 0, 0);
    chk("start_zero", 8'h00, 0, 1);
    cyc(0, 8'h00, 0, 0, 0);
    chk("start_zero_next", 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
Multi-digit cascaded BCD down-counter with start/stop control and a terminal "done" pulse. It is the countdown counterpart of the team's BCD up-counter with CE/CEO chaining. Digits are chained internally by borrow, just as up-counter sections chain by carry. It sits behind a tick-enable generator (CE pulse train) and drives 7-segment display/scan logic and downstream control through Q and DONE.

Parameters:
DIGITS, 2, number of BCD digits (1..4); digit 0 is the least significant, in Q[3:0].

Ports:
CLK    in   1           system clock; all state changes on rising edge
CLR    in   1           asynchronous reset, active high
LOAD   in   1           synchronous parallel load of D into Q
D      in   4*DIGITS    load value, packed BCD
START  in   1           begin/resume counting (level sampled each clock)
STOP   in   1           pause counting (level sampled each clock)
CE     in   1           count enable / tick; one decrement per clock with CE=1 while running
Q      out  4*DIGITS    current count, packed BCD, registered
RUN    out  1           1 while in RUNNING state, registered
DONE   out  1           one-cycle pulse when the count reaches zero, registered
ZERO   out  1           combinational: Q == 0

Behaviour:
- Reset (CLR=1, asynchronous):
  - Q=0, state IDLE, RUN=0, DONE=0, regardless of CLK.
  - Deassertion mid-count leaves the block in IDLE with Q=0.
- States: IDLE, RUNNING. RUN=1 exactly when the state is RUNNING. DONE is a pulse, not a state.
- Per-edge priority, highest first: LOAD > STOP > START > CE decrement.
- LOAD=1:
  - Q<=D, state<=IDLE, DONE<=0.
  - Any D digit >9 is loaded as 9 (saturate per digit), so Q always holds valid BCD.
  - START, STOP and CE in the same cycle are ignored.
- STOP=1, LOAD=0: state<=IDLE, Q held, DONE<=0. STOP wins over a simultaneous START.
- START=1, LOAD=0, STOP=0, state IDLE:
  - If Q!=0: state<=RUNNING, Q unchanged this cycle. CE in the START cycle is ignored; the first decrement happens on the next edge with CE=1.
  - If Q==0: state stays IDLE and DONE<=1 for one cycle.
- START while RUNNING: no effect.
- RUNNING, CE=1:
  - BCD decrement of Q. Digit 0 always borrows-in 1.
  - Digit i with borrow-in: if digit==0, it becomes 9 and borrow-out=1; otherwise it becomes digit-1 and borrow-out=0.
  - Digit i without borrow-in holds.
  - If the decrement result is 0: Q<=0, state<=IDLE, DONE<=1 on the same edge. DONE is high during the first cycle Q shows 0 and clears on the next edge.
  - Q never wraps 0→max. Latency from the Q=1 cycle with CE to DONE high is one edge.
- RUNNING, CE=0: Q held.
- IDLE, CE=1: ignored.
- DONE is 0 in every cycle except the single cycles defined above.
- ZERO reflects the registered Q combinationally; it has no clock latency.
- Width rules: Q and D are exactly 4*DIGITS bits. There is no hidden binary counter; all arithmetic is per-digit BCD.

Test Plan:
- DIGITS=2. CLR pulse mid-run with Q=0x37 → Q=0x00, RUN=0, DONE=0 immediately, before the next CLK edge.
- LOAD D=0x12, START, then CE held 1 → Q sequence 12,11,10,09,08,…,01,00. DONE=1 only in the cycle Q=00, then RUN=0 and Q stays 00 with further CE.
- LOAD D=0x3F (invalid low digit) → Q=0x39. LOAD D=0xA5 → Q=0x95.
- Running from 0x20 with CE every 3rd cycle; STOP at Q=0x15 → Q held at 15 while CE continues. START resumes → 14 on the next CE.
- Same-cycle conflicts:
  - LOAD+START with D=0x05 → Q=05, RUN=0.
  - START+STOP → RUN=0.
  - START+CE from IDLE at Q=0x05 → Q=05 on that edge, 04 on the next CE.
- START with Q=0x00 → DONE=1 for exactly one cycle, RUN stays 0, ZERO=1 throughout.
